// File: rtl/s_mem_sequencer.sv
// Key-search sequencer: steps each candidate key through INIT/SHUFFLE/DECRYPT/CHECK and arbitrates s_memory.
// Optional per-phase watchdog enabled by defining SEQ_WATCHDOG_EN.
module s_mem_sequencer #(
    parameter int                   KEY_WIDTH       = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX         = 24'h3FFFFF,
    parameter int                   WATCHDOG_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 init_start,
    output logic                 shuffle_start,
    output logic                 decrypt_start,
    output logic                 check_start,
    input  logic                 init_done,
    input  logic                 shuffle_done,
    input  logic                 decrypt_done,
    input  logic                 check_done,
    input  logic                 check_pass,
    input  logic [7:0]           init_addr,
    input  logic [7:0]           init_data,
    input  logic                 init_wren,
    input  logic [7:0]           shuffle_addr,
    input  logic [7:0]           shuffle_data,
    input  logic                 shuffle_wren,
    input  logic [7:0]           decrypt_addr,
    input  logic [7:0]           decrypt_data,
    input  logic                 decrypt_wren,
    output logic [7:0]           mem_addr,
    output logic [7:0]           mem_data,
    output logic                 mem_wren,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic                 timeout,
    output logic [2:0]           phase
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INIT     = 3'd1;
    localparam logic [2:0] S_SHUFFLE  = 3'd2;
    localparam logic [2:0] S_DECRYPT  = 3'd3;
    localparam logic [2:0] S_CHECK    = 3'd4;
    localparam logic [2:0] S_NEXT_KEY = 3'd5;
    localparam logic [2:0] S_FOUND    = 3'd6;
    localparam logic [2:0] S_FAIL     = 3'd7;

    if (WATCHDOG_CYCLES < 1) begin : g_bad_watchdog
        $error("WATCHDOG_CYCLES must be at least 1");
    end

    logic [2:0]           state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 first_q, first_d;
    logic                 found_q, found_d;
    logic                 exhausted_q, exhausted_d;
    logic                 in_phase;
    logic                 phase_done;
    logic                 start_accept;

    assign in_phase     = (state_q == S_INIT) || (state_q == S_SHUFFLE) ||
                          (state_q == S_DECRYPT) || (state_q == S_CHECK);
    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_FOUND) ||
                                    (state_q == S_FAIL));

    // Only the done pulse belonging to the current phase counts
    always_comb begin
        phase_done = 1'b0;
        case (state_q)
            S_INIT:    phase_done = init_done;
            S_SHUFFLE: phase_done = shuffle_done;
            S_DECRYPT: phase_done = decrypt_done;
            S_CHECK:   phase_done = check_done;
            default:   phase_done = 1'b0;
        endcase
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
    logic            wd_expired;

    assign wd_expired = in_phase && !phase_done &&
                        (wd_q == WD_W'(WATCHDOG_CYCLES - 1));
`endif

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        first_d     = 1'b0;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        case (state_q)
            S_IDLE, S_FOUND, S_FAIL: begin
                if (start) begin
                    state_d     = S_INIT;
                    key_d       = '0;
                    first_d     = 1'b1;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                end
            end
            S_INIT: begin
                if (init_done) begin
                    state_d = S_SHUFFLE;
                    first_d = 1'b1;
                end
            end
            S_SHUFFLE: begin
                if (shuffle_done) begin
                    state_d = S_DECRYPT;
                    first_d = 1'b1;
                end
            end
            S_DECRYPT: begin
                if (decrypt_done) begin
                    state_d = S_CHECK;
                    first_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (check_done) begin
                    if (check_pass) begin
                        state_d = S_FOUND;
                        found_d = 1'b1;
                    end else if (key_q == KEY_MAX) begin
                        state_d     = S_FAIL;
                        exhausted_d = 1'b1;
                    end else begin
                        state_d = S_NEXT_KEY;
                    end
                end
            end
            S_NEXT_KEY: begin
                if (key_q != KEY_MAX) begin
                    key_d = key_q + 1'b1;
                end
                state_d = S_INIT;
                first_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef SEQ_WATCHDOG_EN
        if (wd_expired) begin
            state_d     = S_FAIL;
            first_d     = 1'b0;
            exhausted_d = 1'b0;
            found_d     = 1'b0;
        end
`endif
    end

`ifdef SEQ_WATCHDOG_EN
    // Counter restarts on every state change, so each phase gets a fresh budget
    always_comb begin
        wd_d = '0;
        if (in_phase && (state_d == state_q)) begin
            wd_d = wd_q + 1'b1;
        end
        timeout_d = timeout_q;
        if (start_accept) begin
            timeout_d = 1'b0;
        end
        if (wd_expired) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            first_q     <= 1'b0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            first_q     <= first_d;
            found_q     <= found_d;
            exhausted_q <= exhausted_d;
        end
    end

    assign init_start    = (state_q == S_INIT)    && first_q;
    assign shuffle_start = (state_q == S_SHUFFLE) && first_q;
    assign decrypt_start = (state_q == S_DECRYPT) && first_q;
    assign check_start   = (state_q == S_CHECK)   && first_q;

    // Memory ownership follows the state directly so requesters see no extra latency
    always_comb begin
        mem_addr = 8'd0;
        mem_data = 8'd0;
        mem_wren = 1'b0;
        case (state_q)
            S_INIT: begin
                mem_addr = init_addr;
                mem_data = init_data;
                mem_wren = init_wren;
            end
            S_SHUFFLE: begin
                mem_addr = shuffle_addr;
                mem_data = shuffle_data;
                mem_wren = shuffle_wren;
            end
            S_DECRYPT: begin
                mem_addr = decrypt_addr;
                mem_data = decrypt_data;
                mem_wren = decrypt_wren;
            end
            default: begin
                mem_addr = 8'd0;
                mem_data = 8'd0;
                mem_wren = 1'b0;
            end
        endcase
    end

    assign key       = key_q;
    assign busy      = in_phase || (state_q == S_NEXT_KEY);
    assign found     = found_q;
    assign exhausted = exhausted_q;
    assign phase     = state_q;

endmodule

// File: doc/s_mem_sequencer.md
S_MEM_SEQUENCER -- requirements
Module: s_mem_sequencer

Interface
REQ-001 Parameter KEY_WIDTH, default 24, width of the brute-force key counter.
REQ-002 Parameter KEY_MAX, default 24'h3FFFFF, last key tried before giving up.
REQ-003 Parameter WATCHDOG_CYCLES, default 4096, per-phase cycle limit; used only under SEQ_WATCHDOG_EN.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin a key search; sampled in IDLE, FOUND and FAIL.
REQ-007 init_start, shuffle_start, decrypt_start, check_start  out  1 each  one-cycle phase launch pulses.
REQ-008 init_done, shuffle_done, decrypt_done, check_done  in  1 each  one-cycle phase completion pulses.
REQ-009 check_pass  in  1  key-accept verdict, valid only in the cycle check_done is high.
REQ-010 init_addr/shuffle_addr/decrypt_addr  in  8 each; init_data/shuffle_data/decrypt_data  in  8 each; init_wren/shuffle_wren/decrypt_wren  in  1 each  requester ports to s_memory.
REQ-011 mem_addr  out  8; mem_data  out  8; mem_wren  out  1  shared s_memory port.
REQ-012 key  out  KEY_WIDTH  key currently under test.
REQ-013 busy, found, exhausted, timeout  out  1 each  status flags; phase  out  3  state encoding.

Function
REQ-014 States: IDLE(0), INIT(1), SHUFFLE(2), DECRYPT(3), CHECK(4), NEXT_KEY(5), FOUND(6), FAIL(7); phase shall equal the encoding.
REQ-015 IDLE/FOUND/FAIL with start=1 -> INIT, key cleared to 0, found/exhausted/timeout cleared.
REQ-016 Each phase state shall assert its *_start for exactly the first cycle after entry; no other *_start shall be high.
REQ-017 INIT->SHUFFLE on init_done; SHUFFLE->DECRYPT on shuffle_done; DECRYPT->CHECK on decrypt_done; transition occurs on the edge that samples done.
REQ-018 CHECK on check_done: check_pass=1 -> FOUND (found=1, key held); check_pass=0 and key==KEY_MAX -> FAIL (exhausted=1); otherwise -> NEXT_KEY.
REQ-019 NEXT_KEY shall increment key by 1 (no wrap past KEY_MAX) and go to INIT after one cycle.
REQ-020 Done pulses for a phase other than the current state shall be ignored; done arriving in the same cycle as *_start shall be accepted.
REQ-021 Memory owner: INIT selects init_*, SHUFFLE selects shuffle_*, DECRYPT selects decrypt_*; mux is combinational from state (zero latency).
REQ-022 In IDLE, CHECK, NEXT_KEY, FOUND, FAIL: mem_wren=0, mem_addr=0, mem_data=0; non-owner wren shall never reach mem_wren.
REQ-023 busy=1 in states INIT..NEXT_KEY, 0 otherwise; start while busy shall be ignored.
REQ-024 found and exhausted shall be mutually exclusive and held until next accepted start or reset.

Reset
REQ-025 reset_n low shall immediately force IDLE, key=0, all *_start=0, mem_wren=0, mem_addr=0, mem_data=0, busy/found/exhausted/timeout=0, phase=0.
REQ-026 Reset mid-phase shall abort without a further pulse; first cycle after release is IDLE with start sampled normally.

Configuration
REQ-027 Macro SEQ_WATCHDOG_EN defined: per-phase counter cleared on phase entry; if it reaches WATCHDOG_CYCLES without the matching done, go to FAIL with timeout=1, exhausted=0.
REQ-028 SEQ_WATCHDOG_EN undefined: no counter synthesized, timeout tied 0, phases wait indefinitely.

Verification
REQ-029 Reset, start pulse; model dones after 3 cycles each, check_pass=1 on first check -> phase 1,2,3,4,6, found=1, key=0, exactly one of each *_start.
REQ-030 check_pass=0 for keys 0..4, 1 for key 5 -> five NEXT_KEY visits, found=1, key=5.
REQ-031 KEY_MAX=3, check_pass always 0 -> FAIL, exhausted=1, key=3, found=0.
REQ-032 Stray decrypt_done and decrypt_wren=1 during INIT -> state unchanged, mem_wren follows init_wren only.
REQ-033 reset_n low mid-SHUFFLE -> same-cycle phase=0, mem_wren=0; start after release restarts at key=0.
REQ-034 SEQ_WATCHDOG_EN, WATCHDOG_CYCLES=16, shuffle_done never -> FAIL after 16 cycles in SHUFFLE, timeout=1.
